// File: rtl/pipeline_delay_hs_if.sv
// Handshake bundle for pipeline_delay_hs: upstream (in_*) and downstream (out_*) valid/ready channels.
// master = the side driving input words and consuming output words; slave = the pipeline itself.
interface pipeline_delay_hs_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipeline_delay_hs.sv
// Multi-lane DEPTH-stage delay pipeline with valid/ready handshake, bubble collapsing and sync flush.
// Optional occupancy counter port `occ` is built when macro PIPE_OCC_EN is defined.
module pipeline_delay_hs #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  pipeline_delay_hs_if.slave         bus
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  localparam int DW = LANES * WIDTH;

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [DW-1:0]    d_q [DEPTH];
  logic [DW-1:0]    d_d [DEPTH];
  logic             in_fire;

  // A stage may advance unless it and every stage downstream of it is full and the output is blocked.
  always_comb begin
    logic full_tail;
    adv       = '0;
    full_tail = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full_tail = full_tail & v_q[i];
      adv[i]    = ~full_tail | bus.out_ready;
    end
  end

  assign bus.in_ready  = adv[0] & ~flush;
  assign bus.out_valid = v_q[DEPTH-1] & ~flush;
  assign bus.out_data  = d_q[DEPTH-1];
  assign in_fire       = bus.in_valid & bus.in_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = in_fire;
      if (in_fire) d_d[0] = bus.in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

`ifdef PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic          out_fire;
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;

  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    occ_d = occ_q + OW'(in_fire) - OW'(out_fire);
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipeline_delay_hs.sv
// Directed bench for pipeline_delay_hs (DEPTH=4, WIDTH=8, LANES=2) with a queue scoreboard.
// occ checks are compiled in only when PIPE_OCC_EN is defined.
module tb_pipeline_delay_hs;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int DW    = WIDTH * LANES;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  pipeline_delay_hs_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

`ifdef PIPE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  pipeline_delay_hs #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
`ifdef PIPE_OCC_EN
    ,
    .occ   (occ)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: entries pushed on input handshake, popped and compared on output handshake.
  always @(negedge clk) begin
    logic [DW-1:0] exp_w;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL out_unexpected: got %0h expected no output (t=%0t)", bus.out_data, $time);
        end else begin
          exp_w = sb.pop_front();
          check("out_data", 32'(bus.out_data), 32'(exp_w));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_check(input string name);
    repeat (8) tick();
    check(name, sb.size(), 0);
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_in_ready", bus.in_ready, 1);
`ifdef PIPE_OCC_EN
    check("rst_occ", occ, 0);
`endif
    tick();

    // Streaming: first output exactly DEPTH cycles after first accept, then no gaps.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = (k < 10);
      bus.in_data  = DW'(16'h0100 + k);
      @(negedge clk);
      check("stream_valid", bus.out_valid, (k >= 4 && k <= 13) ? 1 : 0);
      tick();
    end
    bus.in_valid = 1'b0;
    drain_check("stream_drain");

    // Backpressure fill.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(16'h00A1 + k);
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, (k < 4) ? 1 : 0);
`ifdef PIPE_OCC_EN
      if (k == 4) check("bp_occ_full", occ, 4);
`endif
      if (k < 4) tick();
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", bus.out_valid, 1);
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_head_data", 32'(bus.out_data), 32'h00A1);
    tick();
    bus.in_valid = 1'b0;
    drain_check("bp_drain");

    // Bubble collapse.
    bus.out_ready = 1'b0;
    push(DW'(16'h0011));
    tick();
    tick();
    push(DW'(16'h0022));
    repeat (4) tick();
    @(negedge clk);
    check("bub_out_valid", bus.out_valid, 1);
    check("bub_out_data", 32'(bus.out_data), 32'h0011);
    check("bub_in_ready", bus.in_ready, 1);
`ifdef PIPE_OCC_EN
    check("bub_occ", occ, 2);
`endif
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bub_rel0_valid", bus.out_valid, 1);
    tick();
    @(negedge clk);
    check("bub_rel1_valid", bus.out_valid, 1);
    check("bub_rel1_data", 32'(bus.out_data), 32'h0022);
    tick();
    @(negedge clk);
    check("bub_rel2_valid", bus.out_valid, 0);
    drain_check("bub_drain");

    // Simultaneous accept and emit on a full pipe.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(DW'(16'h0030 + k));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(16'h0034 + k);
      @(negedge clk);
      check("sim_in_ready", bus.in_ready, 1);
      check("sim_out_data", 32'(bus.out_data), 32'(16'h0030 + k));
`ifdef PIPE_OCC_EN
      check("sim_occ", occ, 4);
`endif
      tick();
    end
    bus.in_valid = 1'b0;
    drain_check("sim_drain");

    // Flush with 3 entries in flight and a word offered.
    bus.out_ready = 1'b0;
    push(DW'(16'h0041));
    push(DW'(16'h0042));
    push(DW'(16'h0043));
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(16'h0044);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_in_ready", bus.in_ready, 0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("fl_after_out_valid", bus.out_valid, 0);
    check("fl_after_in_ready", bus.in_ready, 1);
`ifdef PIPE_OCC_EN
    check("fl_after_occ", occ, 0);
`endif
    drain_check("fl_drain");

    // Reset with 2 entries in flight, then resume streaming.
    bus.out_ready = 1'b0;
    push(DW'(16'h0051));
    push(DW'(16'h0052));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_out_data", 32'(bus.out_data), 0);
    check("mrst_in_ready", bus.in_ready, 1);
`ifdef PIPE_OCC_EN
    check("mrst_occ", occ, 0);
`endif
    tick();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(DW'(16'h0061 + k));
    repeat (3) tick();
    @(negedge clk);
    check("mrst_resume_valid", bus.out_valid, 1);
    check("mrst_resume_data", 32'(bus.out_data), 32'h0063);
    drain_check("mrst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
